fpga_cmd_tx: RTL and testbench

Bus initiator for the FPGA command interface: queues command requests from the host-side logic and drives the `command` / `data` / `enable` strobe bus consumed by the LED/ADC command decoder. It enforces setup, pulse and gap spacing in clock cycles. It also provides a sweep engine that issues one command across a channel range (data = 0..N-1) without host involvement. It sits between the MCU-facing request logic and the decoder.

---
 rtl/fpga_cmd_pkg.sv | 18 +
 rtl/fpga_cmd_fifo.sv | 54 +++++
 rtl/fpga_cmd_tx.sv | 152 +++++++++++++++
 tb/tb_fpga_cmd_tx.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cmd_pkg.sv
// Shared types and constants for the FPGA command-bus initiator.
package fpga_cmd_pkg;

  localparam logic [6:0] ADC_SELECT     = 7'h1;
  localparam logic [6:0] RED_LED_ON     = 7'h2;
  localparam logic [6:0] RED_LED_OFF    = 7'h3;
  localparam logic [6:0] GREEN_LED_ON   = 7'h4;
  localparam logic [6:0] GREEN_LED_OFF  = 7'h5;
  localparam logic [7:0] CHANNELS_COUNT = 8'd35;

  typedef struct packed {
    logic [6:0] cmd;
    logic [7:0] data;
  } cmd_req_t;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StGap} state_e;

endpackage

// File: rtl/fpga_cmd_fifo.sv
// Synchronous request FIFO; a pop frees a full slot for a push in the same cycle.
module fpga_cmd_fifo
  import fpga_cmd_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  cmd_req_t                 wdata_i,
  input  logic                     pop_i,
  output cmd_req_t                 rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  cmd_req_t              mem_q [Depth];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [PtrW:0]         count_q;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fpga_cmd_tx.sv
// Command-bus initiator: queues host requests, runs channel sweeps and paces
// the command/data/enable strobe with setup, pulse and gap spacing.
module fpga_cmd_tx
  import fpga_cmd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES   = 5,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [6:0] req_cmd_i,
  input  logic [7:0] req_data_i,
  input  logic       sweep_start_i,
  input  logic [6:0] sweep_cmd_i,
  input  logic [7:0] sweep_count_i,
  output logic       sweep_busy_o,
  output logic       sweep_done_o,
  output logic [6:0] command_o,
  output logic [7:0] data_o,
  output logic       enable_o,
  output logic       busy_o
);

  localparam int unsigned MaxSp     = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned MaxCycles = (MaxSp > GAP_CYCLES) ? MaxSp : GAP_CYCLES;
  localparam int unsigned PhaseW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam int unsigned CntW      = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q;
  logic [PhaseW-1:0] phase_q;
  logic [6:0]        command_q, sweep_cmd_q;
  logic [7:0]        data_q, sweep_count_q, sweep_idx_q;
  logic              enable_q, sweep_busy_q, sweep_done_q, sweep_inflight_q;

  cmd_req_t          req_in, fifo_rdata;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic              phase_last, gap_end, sweep_pending, take, sweep_pop, sweep_fin;

  assign req_in = '{cmd: req_cmd_i, data: req_data_i};

  fpga_cmd_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (req_valid_i),
    .wdata_i(req_in),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    phase_last = 1'b0;
    unique case (state_q)
      StSetup:  phase_last = (phase_q == PhaseW'(SETUP_CYCLES - 1));
      StStrobe: phase_last = (phase_q == PhaseW'(PULSE_CYCLES - 1));
      StGap:    phase_last = (phase_q == PhaseW'(GAP_CYCLES - 1));
      default:  phase_last = 1'b0;
    endcase
  end

  assign gap_end       = (state_q == StGap) && phase_last;
  assign sweep_pending = sweep_busy_q && (sweep_idx_q != sweep_count_q);
  assign take          = (!fifo_empty || sweep_pending) && ((state_q == StIdle) || gap_end);
  assign fifo_pop      = take && !fifo_empty;
  assign sweep_pop     = take && fifo_empty;
  // Finished once every item is issued and the last one has cleared its gap.
  assign sweep_fin     = sweep_busy_q && (sweep_idx_q == sweep_count_q) &&
                         (!sweep_inflight_q || gap_end);

  assign req_ready_o  = !fifo_full || fifo_pop;
  assign command_o    = command_q;
  assign data_o       = data_q;
  assign enable_o     = enable_q;
  assign sweep_busy_o = sweep_busy_q;
  assign sweep_done_o = sweep_done_q;
  assign busy_o       = (state_q != StIdle) || (fifo_count != '0) || sweep_busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= StIdle;
      phase_q          <= '0;
      command_q        <= '0;
      data_q           <= '0;
      enable_q         <= 1'b0;
      sweep_busy_q     <= 1'b0;
      sweep_done_q     <= 1'b0;
      sweep_inflight_q <= 1'b0;
      sweep_cmd_q      <= '0;
      sweep_count_q    <= '0;
      sweep_idx_q      <= '0;
    end else begin
      sweep_done_q <= 1'b0;
      if (gap_end) sweep_inflight_q <= 1'b0;

      if (take) begin
        state_q <= StSetup;
        phase_q <= '0;
        if (fifo_pop) begin
          command_q <= fifo_rdata.cmd;
          data_q    <= fifo_rdata.data;
        end else begin
          command_q        <= sweep_cmd_q;
          data_q           <= sweep_idx_q;
          sweep_idx_q      <= sweep_idx_q + 8'd1;
          sweep_inflight_q <= 1'b1;
        end
      end else begin
        unique case (state_q)
          StSetup: begin
            phase_q <= phase_last ? '0 : phase_q + 1'b1;
            if (phase_last) begin
              state_q  <= StStrobe;
              enable_q <= 1'b1;
            end
          end
          StStrobe: begin
            phase_q <= phase_last ? '0 : phase_q + 1'b1;
            if (phase_last) begin
              state_q  <= StGap;
              enable_q <= 1'b0;
            end
          end
          StGap: begin
            phase_q <= phase_last ? '0 : phase_q + 1'b1;
            if (phase_last) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end

      if (sweep_fin) begin
        sweep_busy_q <= 1'b0;
        sweep_done_q <= 1'b1;
      end else if (sweep_start_i && !sweep_busy_q) begin
        sweep_busy_q  <= 1'b1;
        sweep_cmd_q   <= sweep_cmd_i;
        sweep_count_q <= sweep_count_i;
        sweep_idx_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fpga_cmd_tx.sv
// Directed bench for fpga_cmd_tx: default-parameter instance plus a 3/2/1 instance.
module tb_fpga_cmd_tx;
  import fpga_cmd_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, sweep_start;
  logic [6:0] req_cmd, sweep_cmd;
  logic [7:0] req_data, sweep_count;

  logic       req_ready, sweep_busy, sweep_done, enable, busy;
  logic [6:0] command;
  logic [7:0] data;
  logic       req_ready2, sweep_busy2, sweep_done2, enable2, busy2;
  logic [6:0] command2;
  logic [7:0] data2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpga_cmd_tx dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_cmd_i(req_cmd), .req_data_i(req_data), .sweep_start_i(sweep_start),
    .sweep_cmd_i(sweep_cmd), .sweep_count_i(sweep_count), .sweep_busy_o(sweep_busy),
    .sweep_done_o(sweep_done), .command_o(command), .data_o(data), .enable_o(enable),
    .busy_o(busy)
  );

  fpga_cmd_tx #(
    .SETUP_CYCLES(3), .PULSE_CYCLES(2), .GAP_CYCLES(1), .FIFO_DEPTH(4)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready2),
    .req_cmd_i(req_cmd), .req_data_i(req_data), .sweep_start_i(sweep_start),
    .sweep_cmd_i(sweep_cmd), .sweep_count_i(sweep_count), .sweep_busy_o(sweep_busy2),
    .sweep_done_o(sweep_done2), .command_o(command2), .data_o(data2), .enable_o(enable2),
    .busy_o(busy2)
  );

  typedef struct {
    int         cyc;
    logic [6:0] cmd;
    logic [7:0] data;
  } strobe_t;

  typedef struct {
    logic       v;
    logic [6:0] cmd;
    logic [7:0] dat;
    logic       rdy;
    logic       en;
    logic [6:0] ecmd;
    logic [7:0] edat;
    logic       bsy;
  } vec_t;

  typedef struct {
    logic [6:0] cmd;
    logic [7:0] dat;
    int         wait_cycles;
  } push_t;

  // Bus monitors, sampled on the falling edge.
  int        cyc = 0;
  strobe_t   st_q[$];
  int        done_cnt = 0;
  int        done_cyc = 0;
  logic      en_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (enable && !en_prev) st_q.push_back('{cyc, command, data});
    en_prev = enable;
    if (sweep_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  logic [14:0] bus2_prev = '0;
  logic        en2_prev = 1'b0;
  int          since2 = 0;
  int          plen2 = 0;
  int          setup2_q[$], pulse2_q[$], rise2_q[$];

  always @(negedge clk) begin
    if ({command2, data2} != bus2_prev) since2 = 0;
    else since2++;
    bus2_prev = {command2, data2};
    if (enable2 && !en2_prev) begin
      setup2_q.push_back(since2);
      rise2_q.push_back(cyc);
      plen2 = 0;
    end
    if (enable2) plen2++;
    if (!enable2 && en2_prev) pulse2_q.push_back(plen2);
    en2_prev = enable2;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid   = 1'b0;
    sweep_start = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_strobes(input int n, input int limit, input string name);
    int w = 0;
    while (st_q.size() < n && w < limit) begin
      step();
      w++;
    end
    chk(name, int'(st_q.size() >= n), 1);
  endtask

  task automatic wait_done(input int n, input int limit, input string name);
    int w = 0;
    while (done_cnt < n && w < limit) begin
      step();
      w++;
    end
    chk(name, int'(done_cnt >= n), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    vecs[11];
    push_t   pushes[6];
    int      base, b2, d0, w;

    vecs[0]  = '{1'b1, 7'h2, 8'h07, 1'b1, 1'b0, 7'h0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 7'h0, 8'h00, 1'b1, 1'b0, 7'h0, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 7'h0, 8'h00, 1'b1, 1'b0, 7'h2, 8'h07, 1'b1};
    vecs[3]  = '{1'b0, 7'h0, 8'h00, 1'b1, 1'b1, 7'h2, 8'h07, 1'b1};
    vecs[4]  = '{1'b0, 7'h0, 8'h00, 1'b1, 1'b0, 7'h2, 8'h07, 1'b1};
    vecs[5]  = '{1'b0, 7'h0, 8'h00, 1'b1, 1'b0, 7'h2, 8'h07, 1'b1};
    vecs[6]  = '{1'b0, 7'h0, 8'h00, 1'b1, 1'b0, 7'h2, 8'h07, 1'b1};
    vecs[7]  = '{1'b0, 7'h0, 8'h00, 1'b1, 1'b0, 7'h2, 8'h07, 1'b1};
    vecs[8]  = '{1'b0, 7'h0, 8'h00, 1'b1, 1'b0, 7'h2, 8'h07, 1'b1};
    vecs[9]  = '{1'b0, 7'h0, 8'h00, 1'b1, 1'b0, 7'h2, 8'h07, 1'b0};
    vecs[10] = '{1'b0, 7'h0, 8'h00, 1'b1, 1'b0, 7'h2, 8'h07, 1'b0};

    pushes[0] = '{RED_LED_ON,    8'h10, 0};
    pushes[1] = '{RED_LED_OFF,   8'h11, 0};
    pushes[2] = '{GREEN_LED_ON,  8'h12, 0};
    pushes[3] = '{GREEN_LED_OFF, 8'h13, 0};
    pushes[4] = '{ADC_SELECT,    8'h14, 0};
    pushes[5] = '{RED_LED_ON,    8'h15, 3};

    req_valid = 1'b0; req_cmd = '0; req_data = '0;
    sweep_start = 1'b0; sweep_cmd = '0; sweep_count = '0;
    rst = 1'b1;
    repeat (3) step();

    // Reset values
    chk("rst_command", int'(command), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sweep_busy", int'(sweep_busy), 0);
    chk("rst_sweep_done", int'(sweep_done), 0);
    chk("rst2_ready", int'(req_ready2), 1);
    chk("rst2_busy", int'(busy2 | sweep_busy2 | sweep_done2), 0);
    rst = 1'b0;
    step();

    // Single request, cycle by cycle
    for (int i = 0; i < 11; i++) begin
      req_valid = vecs[i].v;
      req_cmd   = vecs[i].cmd;
      req_data  = vecs[i].dat;
      #1;
      chk($sformatf("single[%0d].ready", i), int'(req_ready), int'(vecs[i].rdy));
      chk($sformatf("single[%0d].enable", i), int'(enable), int'(vecs[i].en));
      chk($sformatf("single[%0d].command", i), int'(command), int'(vecs[i].ecmd));
      chk($sformatf("single[%0d].data", i), int'(data), int'(vecs[i].edat));
      chk($sformatf("single[%0d].busy", i), int'(busy), int'(vecs[i].bsy));
      step();
    end

    // 3/2/1 timing on the second instance
    do_reset();
    b2 = setup2_q.size();
    req_valid = 1'b1; req_cmd = RED_LED_ON; req_data = 8'hA1;
    step();
    req_cmd = RED_LED_OFF; req_data = 8'hB2;
    step();
    req_valid = 1'b0;
    repeat (30) step();
    chk("p321_strobes", int'(setup2_q.size() - b2 >= 2 && pulse2_q.size() - b2 >= 2), 1);
    if (setup2_q.size() - b2 >= 2 && pulse2_q.size() - b2 >= 2) begin
      chk("p321_setup0", setup2_q[b2], 3);
      chk("p321_setup1", setup2_q[b2+1], 3);
      chk("p321_pulse0", pulse2_q[b2], 2);
      chk("p321_pulse1", pulse2_q[b2+1], 2);
      chk("p321_period", rise2_q[b2+1] - rise2_q[b2], 6);
    end

    // FIFO fill: six back-to-back pushes
    do_reset();
    base = st_q.size();
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_cmd   = pushes[i].cmd;
      req_data  = pushes[i].dat;
      w = 0;
      #1;
      while (!req_ready && w < 20) begin
        step();
        #1;
        w++;
      end
      chk($sformatf("fifo_wait[%0d]", i), w, pushes[i].wait_cycles);
      step();
    end
    req_valid = 1'b0;
    wait_strobes(base + 6, 100, "fifo_drain_timeout");
    if (st_q.size() >= base + 6) begin
      chk("fifo_count", st_q.size() - base, 6);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("fifo[%0d].cmd", i), int'(st_q[base+i].cmd), int'(pushes[i].cmd));
        chk($sformatf("fifo[%0d].data", i), int'(st_q[base+i].data), int'(pushes[i].dat));
        if (i > 0) chk($sformatf("fifo[%0d].period", i), st_q[base+i].cyc - st_q[base+i-1].cyc, 7);
      end
    end

    // Full sweep across all channels, with an ignored second start
    do_reset();
    base = st_q.size();
    d0 = done_cnt;
    sweep_cmd = ADC_SELECT; sweep_count = CHANNELS_COUNT; sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    chk("sweep_busy_set", int'(sweep_busy), 1);
    repeat (20) step();
    sweep_cmd = GREEN_LED_ON; sweep_count = 8'd2; sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    wait_done(d0 + 1, 400, "sweep_done_timeout");
    repeat (20) step();
    chk("sweep_strobes", st_q.size() - base, 35);
    chk("sweep_done_pulses", done_cnt - d0, 1);
    chk("sweep_busy_clear", int'(sweep_busy), 0);
    chk("sweep_idle_busy", int'(busy), 0);
    if (st_q.size() - base == 35) begin
      for (int i = 0; i < 35; i++) begin
        chk($sformatf("sweep[%0d].cmd", i), int'(st_q[base+i].cmd), int'(ADC_SELECT));
        chk($sformatf("sweep[%0d].data", i), int'(st_q[base+i].data), i);
        if (i > 0) chk($sformatf("sweep[%0d].period", i), st_q[base+i].cyc - st_q[base+i-1].cyc, 7);
      end
      chk("sweep_done_timing", done_cyc - st_q[base+34].cyc, 6);
    end

    // Host request pre-empts a running sweep
    do_reset();
    base = st_q.size();
    d0 = done_cnt;
    sweep_cmd = ADC_SELECT; sweep_count = 8'd20; sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    wait_strobes(base + 11, 200, "preempt_wait_timeout");
    req_valid = 1'b1; req_cmd = GREEN_LED_OFF; req_data = 8'h03;
    #1;
    chk("preempt_ready", int'(req_ready), 1);
    step();
    req_valid = 1'b0;
    wait_done(d0 + 1, 300, "preempt_done_timeout");
    chk("preempt_strobes", st_q.size() - base, 21);
    if (st_q.size() - base == 21) begin
      chk("preempt_item10", int'(st_q[base+10].data), 10);
      chk("preempt_host_cmd", int'(st_q[base+11].cmd), 5);
      chk("preempt_host_data", int'(st_q[base+11].data), 3);
      chk("preempt_resume_cmd", int'(st_q[base+12].cmd), int'(ADC_SELECT));
      chk("preempt_resume_data", int'(st_q[base+12].data), 11);
      chk("preempt_last_data", int'(st_q[base+20].data), 19);
    end

    // Zero-length sweep
    do_reset();
    base = st_q.size();
    d0 = done_cnt;
    sweep_cmd = RED_LED_ON; sweep_count = 8'd0; sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    #1;
    chk("zero_busy_c1", int'(sweep_busy), 1);
    chk("zero_done_c1", int'(sweep_done), 0);
    step();
    #1;
    chk("zero_busy_c2", int'(sweep_busy), 0);
    chk("zero_done_c2", int'(sweep_done), 1);
    step();
    #1;
    chk("zero_done_c3", int'(sweep_done), 0);
    repeat (10) step();
    chk("zero_strobes", st_q.size() - base, 0);
    chk("zero_done_pulses", done_cnt - d0, 1);

    // Asynchronous reset during a sweep strobe
    do_reset();
    d0 = done_cnt;
    sweep_cmd = RED_LED_OFF; sweep_count = 8'd5; sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    w = 0;
    while (!enable && w < 20) begin
      step();
      w++;
    end
    chk("rstmid_reached_strobe", int'(enable), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_enable", int'(enable), 0);
    chk("rstmid_command", int'(command), 0);
    chk("rstmid_data", int'(data), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_sweep_busy", int'(sweep_busy), 0);
    chk("rstmid_req_ready", int'(req_ready), 1);
    step();
    rst = 1'b0;
    base = st_q.size();
    repeat (60) step();
    chk("rstmid_no_done", done_cnt - d0, 0);
    chk("rstmid_no_strobes", st_q.size() - base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
